// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU and load/mul
// writeback paths, and tracks pending long-latency destinations for RAW stalls.
// Optional stall counter: define STALL_CNT_EN.
module regfile_wb_arbiter #(
  parameter int unsigned NREG = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [4:0]      req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4:0]      req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            stall,
  output logic            rf_regwrite,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  localparam int unsigned RD_W = 5;

  logic            last_grant;
  logic            grant0;
  logic            grant1;
  logic            contend;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Round-robin: last_grant=1 means req1 won the last contested cycle.
  always_comb begin
    contend = req0_valid & req1_valid;
    grant0  = req0_valid & (~req1_valid | last_grant);
    grant1  = req1_valid & (~req0_valid | ~last_grant);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (contend) begin
      last_grant <= grant1;
    end
  end

  // Registered write port; writes to x0 are dropped and rd/data hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_regwrite <= 1'b0;
      rf_rd       <= '0;
      rf_data     <= '0;
    end else begin
      rf_regwrite <= 1'b0;
      if (grant0 && req0_rd != RD_W'(0)) begin
        rf_regwrite <= 1'b1;
        rf_rd       <= req0_rd;
        rf_data     <= req0_data;
      end else if (grant1 && req1_rd != RD_W'(0)) begin
        rf_regwrite <= 1'b1;
        rf_rd       <= req1_rd;
        rf_data     <= req1_data;
      end
    end
  end

  // Scoreboard update: clear on accepted req1, set on issue; set applied last so it wins.
  always_comb begin
    pending_nxt = pending;
    if (grant1) begin
      pending_nxt[req1_rd] = 1'b0;
    end
    if (issue_valid && issue_rd != RD_W'(0)) begin
      pending_nxt[issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_comb begin
    stall = ((chk_rs1 != RD_W'(0)) & pending[chk_rs1]) |
            ((chk_rs2 != RD_W'(0)) & pending[chk_rs2]);
  end

`ifdef STALL_CNT_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if (stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued when a
// grant is expected and compared one cycle later at the register-file port.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        stall;
  logic        rf_regwrite;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks;
  int failures;
  wr_t exp_q[$];
  logic [4:0]  hold_rd;
  logic [31:0] hold_data;

  regfile_wb_arbiter #(.NREG(32), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_rd     (req0_rd),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_rd     (req1_rd),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .stall       (stall),
    .rf_regwrite (rf_regwrite),
    .rf_rd       (rf_rd),
    .rf_data     (rf_data)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check same-cycle outputs, queue the expected write,
  // then compare the register-file port after the edge.
  task automatic drive(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic e_g0, input logic e_g1, input logic e_stall);
    wr_t e;
    wr_t got;
    req0_valid = v0; req0_rd = rd0; req0_data = d0;
    req1_valid = v1; req1_rd = rd1; req1_data = d1;
    issue_valid = iv; issue_rd = ird;
    chk_rs1 = rs1; chk_rs2 = rs2;
    #1;
    chk("req0_ready", 32'(req0_ready), 32'(e_g0));
    chk("req1_ready", 32'(req1_ready), 32'(e_g1));
    chk("stall", 32'(stall), 32'(e_stall));
    if (e_g0 && rd0 != 5'd0) begin
      e = '{we: 1'b1, rd: rd0, data: d0};
    end else if (e_g1 && rd1 != 5'd0) begin
      e = '{we: 1'b1, rd: rd1, data: d1};
    end else begin
      e = '{we: 1'b0, rd: hold_rd, data: hold_data};
    end
    hold_rd = e.rd;
    hold_data = e.data;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      chk("rf_regwrite", 32'(rf_regwrite), 32'(got.we));
      chk("rf_rd", 32'(rf_rd), 32'(got.rd));
      chk("rf_data", rf_data, got.data);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    hold_rd = 5'd0;
    hold_data = 32'd0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_rd = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_rd = 5'd0; req1_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    #3;
    chk("rst_regwrite", 32'(rf_regwrite), 32'd0);
    chk("rst_rd", 32'(rf_rd), 32'd0);
    chk("rst_data", rf_data, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Idle, then a lone ALU write.
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(1, 5'd5, 32'h1234,  0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);

    // Contention for three cycles: req0, req1, req0.
    drive(1, 5'd1, 32'hA1,    1, 5'd2, 32'hB2, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    drive(1, 5'd3, 32'hA3,    1, 5'd2, 32'hB2, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    drive(1, 5'd3, 32'hA3,    1, 5'd4, 32'hB4, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    drive(0, 5'd0, 32'd0,     1, 5'd4, 32'hB4, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0,  0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // Scoreboard set, RAW stall, clear, and same-cycle set-over-clear.
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0,  1, 5'd7, 5'd0, 5'd0, 0, 0, 0);
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0,  0, 5'd0, 5'd7, 5'd0, 0, 0, 1);
    drive(0, 5'd0, 32'd0,     1, 5'd7, 32'h77, 0, 5'd0, 5'd7, 5'd0, 0, 1, 1);
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0,  0, 5'd0, 5'd7, 5'd0, 0, 0, 0);
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0,  1, 5'd7, 5'd7, 5'd0, 0, 0, 0);
    drive(0, 5'd0, 32'd0,     1, 5'd7, 32'h88, 1, 5'd7, 5'd0, 5'd7, 0, 1, 1);
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0,  0, 5'd0, 5'd0, 5'd7, 0, 0, 1);
    drive(0, 5'd0, 32'd0,     1, 5'd7, 32'h99, 0, 5'd0, 5'd0, 5'd7, 0, 1, 1);
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0,  0, 5'd0, 5'd7, 5'd7, 0, 0, 0);

    // x0 destinations: write dropped, never pending.
    drive(1, 5'd0, 32'hFFFF,  0, 5'd0, 32'd0,  0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0,  1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0,  0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // Reset while pending[3]=1 and an ALU write is granted but not yet written.
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0,  1, 5'd3, 5'd0, 5'd0, 0, 0, 0);
    req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h5555;
    issue_valid = 1'b0; issue_rd = 5'd0; chk_rs1 = 5'd3; chk_rs2 = 5'd0;
    #1;
    chk("pre_rst_ready0", 32'(req0_ready), 32'd1);
    chk("pre_rst_stall", 32'(stall), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_regwrite", 32'(rf_regwrite), 32'd0);
    chk("mid_rst_rd", 32'(rf_rd), 32'd0);
    chk("mid_rst_data", rf_data, 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    #1;
    rst = 1'b0;
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_regwrite", 32'(rf_regwrite), 32'd0);
    chk("post_rst_rd", 32'(rf_rd), 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
`ifdef STALL_CNT_EN
    chk("post_rst_cnt", 32'(stall_cnt), 32'd0);
`endif
    hold_rd = 5'd0;
    hold_data = 32'd0;

    // Round-robin pointer is back to req0-first after reset.
    drive(1, 5'd10, 32'hAA,   1, 5'd11, 32'hBB, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0,   0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

`ifdef STALL_CNT_EN
    drive(0, 5'd0, 32'd0,     0, 5'd0, 32'd0,   1, 5'd6, 5'd0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 5'd0, 32'd0,   0, 5'd0, 32'd0,   0, 5'd0, 5'd6, 5'd0, 0, 0, 1);
    end
    chk("stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (regwrite/rd/rd_data) between two writeback requesters: req0, the single-cycle ALU path, and req1, the multi-cycle load/mul path. It keeps a pending-write scoreboard for long-latency destinations and raises a stall to the issue stage on RAW hazards. It sits between the execute/memory stages and the register file.

Parameters:
NREG, 32, number of architectural registers; scoreboard width; x0 hardwired zero.
XLEN, 32, writeback data width.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req0_valid  input  1  ALU writeback request
req0_rd  input  5  ALU destination
req0_data  input  XLEN  ALU result
req0_ready  output  1  ALU request accepted this cycle
req1_valid  input  1  load/mul writeback request
req1_rd  input  5  load/mul destination
req1_data  input  XLEN  load/mul result
req1_ready  output  1  load/mul request accepted this cycle
issue_valid  input  1  long-latency instruction issued
issue_rd  input  5  its destination
chk_rs1  input  5  source 1 of the instruction in issue
chk_rs2  input  5  source 2 of the instruction in issue
stall  output  1  RAW hazard on a pending register
rf_regwrite  output  1  register-file write enable
rf_rd  output  5  register-file write address
rf_data  output  XLEN  register-file write data

Behaviour:
- Reset (async, rst=1): rf_regwrite=0, rf_rd=0, rf_data=0, last_grant=1 (req0 wins first contention), pending[]=0. Release takes effect on the next clk edge.
- Arbitration is combinational per cycle. A lone valid is granted. When both are valid, the requester not granted last time wins (round-robin on last_grant). last_grant updates only on a contested cycle.
- reqN_ready = grantN. Handshake completes when valid&ready. Requesters hold valid/rd/data stable until ready.
- Write port is registered: 1-cycle latency. In the cycle after a grant, rf_regwrite=1 with the winner's rd/data. With no grant, rf_regwrite=0 and rf_rd/rf_data hold their previous values.
- A granted request with rd=0 completes the handshake but drives rf_regwrite=0 (the write is dropped).
- Scoreboard:
  - pending[issue_rd] sets on issue_valid when issue_rd!=0.
  - pending[rd] clears on an accepted req1 handshake.
  - req0 never touches pending.
  - Same-cycle set and clear on the same rd: set wins.
  - issue_valid with issue_rd already pending: stays set (no counting).
- stall = (chk_rs1!=0 & pending[chk_rs1]) | (chk_rs2!=0 & pending[chk_rs2]). It is combinational from registered pending. A clear lands one cycle later, which covers the register-file write latency.
- req1 for an rd that is not pending: the write is still performed and the scoreboard is unchanged.
- Reset asserted mid-transfer: the in-flight write is lost, pending is cleared, and outputs go to reset values immediately.

Optional Feature:
STALL_CNT_EN. When defined, adds port stall_cnt (output, 16 bits). It resets to 0, increments on each cycle with stall=1, and saturates at 16'hFFFF. When undefined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then idle -> rf_regwrite=0, stall=0, both ready=0.
- req0 only, rd=5, data=32'h1234 -> req0_ready=1 same cycle. Next cycle rf_regwrite=1, rf_rd=5, rf_data=32'h1234.
- Both valid for 3 cycles, each re-asserting after acceptance -> grants ordered req0, req1, req0. Each write appears one cycle after its grant.
- issue_valid rd=7, then chk_rs1=7 -> stall=1. Then req1 rd=7 is accepted -> stall=0 from the following cycle. Same-cycle issue rd=7 with req1 rd=7 clear -> pending[7] stays 1.
- req0 rd=0 data=32'hFFFF -> ready=1, next-cycle rf_regwrite=0. issue_rd=0 then chk_rs1=0 -> stall=0.
- rst pulsed mid-cycle while pending[3]=1 and a write is in flight -> outputs 0 immediately, pending[3]=0. With STALL_CNT_EN, holding a stall for 5 cycles -> stall_cnt=5.
